tray_lift_ctrl: RTL and testbench

Closed-loop sequencer that drives the tray lift motor to a commanded height. It consumes the tray height and the station code/change flag from the height sensor. It accepts one target per valid/ready handshake and issues mutually exclusive up/down motor commands. It waits for the tray to settle, checks the result, and reports done or fault to the station scheduler above it.

---
 rtl/tray_lift_ctrl_if.sv | 29 ++
 rtl/tray_lift_ctrl.sv | 172 +++++++++++++++++
 tb/tb_tray_lift_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tray_lift_ctrl_if.sv
// Tray lift control bundle: scheduler command handshake, height sensor feed,
// motor drive and status between the scheduler/plant side and the sequencer.
interface tray_lift_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_height;
  logic [31:0] tray_height;
  logic [7:0]  tray_station;
  logic        station_changed;
  logic        motor_up;
  logic        motor_dn;
  logic        busy;
  logic        done;
  logic        fault;
  logic [1:0]  fault_code;
  logic        fault_clr;

  // Scheduler / sensor side
  modport master (
    output cmd_valid, cmd_height, tray_height, tray_station, station_changed, fault_clr,
    input  cmd_ready, motor_up, motor_dn, busy, done, fault, fault_code
  );

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_height, tray_height, tray_station, station_changed, fault_clr,
    output cmd_ready, motor_up, motor_dn, busy, done, fault, fault_code
  );
endinterface

// File: rtl/tray_lift_ctrl.sv
// Closed-loop tray lift sequencer: moves toward a commanded height, waits for
// the tray to settle, retries small corrections and reports done or fault.
module tray_lift_ctrl #(
  parameter int unsigned HEIGHT_TOL = 4,
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned STALL_CYC  = 256,
  parameter int unsigned MAX_RETRY  = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic          clk,
  input  logic          rst,
  tray_lift_ctrl_if.slave bus
);

  localparam int unsigned H_W     = 32;
  localparam int unsigned D_W     = H_W + 1;
  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_MOVE_UP = 3'd1;
  localparam logic [2:0] S_MOVE_DN = 3'd2;
  localparam logic [2:0] S_SETTLE  = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_FAULT   = 3'd5;

  localparam logic [7:0] ST_ZERO = 8'h00;
  localparam logic [7:0] ST_UP   = 8'h02;
  localparam logic [7:0] ST_DN   = 8'h03;

  localparam logic [1:0] FC_NONE  = 2'd0;
  localparam logic [1:0] FC_STALL = 2'd1;
  localparam logic [1:0] FC_DIR   = 2'd2;
  localparam logic [1:0] FC_RETRY = 2'd3;

  logic [2:0]         state, state_nxt;
  logic [H_W-1:0]     target, target_nxt;
  logic [RETRY_W-1:0] retry, retry_nxt;
  logic [CNT_W-1:0]   stall_cnt, stall_nxt, stall_inc;
  logic [CNT_W-1:0]   settle_cnt, settle_nxt, settle_inc;
  logic [1:0]         code_nxt;
  logic [D_W-1:0]     h_ext, t_ext, tol_ext;
  logic               up_reached, dn_reached, stall_hit, settle_hit, target_in_tol;

  // 33-bit absolute difference so extreme heights never wrap into tolerance
  function automatic logic within_tol(input logic [H_W-1:0] a, input logic [H_W-1:0] b);
    logic [D_W-1:0] d;
    d = (a >= b) ? (D_W'(a) - D_W'(b)) : (D_W'(b) - D_W'(a));
    return d <= D_W'(HEIGHT_TOL);
  endfunction

  always_comb begin
    h_ext         = D_W'(bus.tray_height);
    t_ext         = D_W'(target);
    tol_ext       = D_W'(HEIGHT_TOL);
    up_reached    = (h_ext + tol_ext) >= t_ext;
    dn_reached    = h_ext <= (t_ext + tol_ext);
    stall_inc     = stall_cnt + CNT_W'(1);
    settle_inc    = settle_cnt + CNT_W'(1);
    stall_hit     = 32'(stall_inc) >= STALL_CYC;
    settle_hit    = 32'(settle_inc) >= SETTLE_CYC;
    target_in_tol = within_tol(target, bus.tray_height);
  end

  // Next-state and next-register logic
  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    retry_nxt  = retry;
    stall_nxt  = stall_cnt;
    settle_nxt = settle_cnt;
    code_nxt   = bus.fault_code;

    case (state)
      S_IDLE: begin
        if (bus.cmd_valid && bus.cmd_ready) begin
          target_nxt = bus.cmd_height;
          retry_nxt  = '0;
          if (within_tol(bus.cmd_height, bus.tray_height)) state_nxt = S_SETTLE;
          else if (bus.cmd_height > bus.tray_height)       state_nxt = S_MOVE_UP;
          else                                             state_nxt = S_MOVE_DN;
        end
      end
      S_MOVE_UP: begin
        stall_nxt = (bus.tray_station == ST_UP) ? '0 : stall_inc;
        if (bus.tray_station == ST_DN) begin
          state_nxt = S_FAULT;
          code_nxt  = FC_DIR;
        end else if (bus.tray_station != ST_UP && stall_hit) begin
          state_nxt = S_FAULT;
          code_nxt  = FC_STALL;
        end else if (up_reached) begin
          state_nxt = S_SETTLE;
        end
      end
      S_MOVE_DN: begin
        stall_nxt = (bus.tray_station == ST_DN) ? '0 : stall_inc;
        if (bus.tray_station == ST_UP) begin
          state_nxt = S_FAULT;
          code_nxt  = FC_DIR;
        end else if (bus.tray_station != ST_DN && stall_hit) begin
          state_nxt = S_FAULT;
          code_nxt  = FC_STALL;
        end else if (dn_reached || bus.tray_station == ST_ZERO) begin
          state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        settle_nxt = bus.station_changed ? '0 : settle_inc;
        if (!bus.station_changed && settle_hit) begin
          if (target_in_tol) begin
            state_nxt = S_DONE;
          end else if (retry < RETRY_W'(MAX_RETRY)) begin
            retry_nxt = retry + RETRY_W'(1);
            state_nxt = (target > bus.tray_height) ? S_MOVE_UP : S_MOVE_DN;
          end else begin
            state_nxt = S_FAULT;
            code_nxt  = FC_RETRY;
          end
        end
      end
      S_DONE: state_nxt = S_IDLE;
      S_FAULT: begin
        if (bus.fault_clr) begin
          state_nxt = S_IDLE;
          code_nxt  = FC_NONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        code_nxt  = FC_NONE;
      end
    endcase

    // Every state entry starts with fresh stall/settle windows
    if (state_nxt != state) begin
      stall_nxt  = '0;
      settle_nxt = '0;
    end
  end

  // State and registered outputs, decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      target         <= '0;
      retry          <= '0;
      stall_cnt      <= '0;
      settle_cnt     <= '0;
      bus.cmd_ready  <= 1'b1;
      bus.motor_up   <= 1'b0;
      bus.motor_dn   <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.fault      <= 1'b0;
      bus.fault_code <= FC_NONE;
    end else begin
      state          <= state_nxt;
      target         <= target_nxt;
      retry          <= retry_nxt;
      stall_cnt      <= stall_nxt;
      settle_cnt     <= settle_nxt;
      bus.cmd_ready  <= (state_nxt == S_IDLE);
      bus.motor_up   <= (state_nxt == S_MOVE_UP);
      bus.motor_dn   <= (state_nxt == S_MOVE_DN);
      bus.busy       <= (state_nxt != S_IDLE) && (state_nxt != S_FAULT);
      bus.done       <= (state_nxt == S_DONE);
      bus.fault      <= (state_nxt == S_FAULT);
      bus.fault_code <= code_nxt;
    end
  end

endmodule

// File: tb/tb_tray_lift_ctrl.sv
// Self-checking bench for tray_lift_ctrl: a simple lift plant model feeds the
// sensor inputs, and a result scoreboard matches each command to its outcome.
module tb_tray_lift_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tray_lift_ctrl_if tlif ();

  tray_lift_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (tlif.slave)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] exp_q[$];   // 0 = done, 1..3 = fault code
  bit          stuck      = 1'b0;
  int          coast_left = 0;
  bit          was_on     = 1'b0;
  bit          last_up    = 1'b0;
  int          up_cycles  = 0;
  bit          done_q     = 1'b0;
  bit          fault_q    = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    if (exp_q.size() == 0) check("unexpected_result", obs, 32'hDEAD);
    else                   check("result", obs, exp_q.pop_front());
  endtask

  // Output monitor: exclusivity, done width, and scoreboard matching
  always @(negedge clk) begin
    if (!rst) begin
      check("motor_excl", 32'(tlif.motor_up & tlif.motor_dn), 32'd0);
      if (tlif.motor_up) up_cycles++;
      if (tlif.done) begin
        check("done_width", 32'(done_q), 32'd0);
        sb_pop(32'd0);
      end
      if (tlif.fault && !fault_q) sb_pop(32'(tlif.fault_code));
    end
    done_q  = rst ? 1'b0 : tlif.done;
    fault_q = rst ? 1'b0 : tlif.fault;
  end

  // Lift plant: one height step per motor cycle, optional stall and overshoot
  task automatic plant();
    bit on;
    on = tlif.motor_up | tlif.motor_dn;
    if (stuck) begin
      tlif.tray_station = 8'h01; tlif.station_changed = 1'b0;
    end else if (tlif.motor_up) begin
      tlif.tray_height = tlif.tray_height + 32'd1;
      tlif.tray_station = 8'h02; tlif.station_changed = 1'b1;
    end else if (tlif.motor_dn) begin
      tlif.tray_height = tlif.tray_height - 32'd1;
      tlif.tray_station = 8'h03; tlif.station_changed = 1'b1;
    end else if (was_on && coast_left > 0) begin
      tlif.tray_height = last_up ? 32'd220 : 32'd180;
      coast_left--;
      tlif.tray_station = 8'h01; tlif.station_changed = 1'b1;
    end else begin
      tlif.tray_station = 8'h01; tlif.station_changed = 1'b0;
    end
    if (on) last_up = tlif.motor_up;
    was_on = on;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    plant();
  endtask

  task automatic send_cmd(input logic [31:0] start_h, input logic [31:0] cmd, input logic [31:0] expect_res);
    tlif.tray_height     = start_h;
    tlif.tray_station    = 8'h01;
    tlif.station_changed = 1'b0;
    tlif.cmd_valid       = 1'b1;
    tlif.cmd_height      = cmd;
    up_cycles            = 0;
    exp_q.push_back(expect_res);
    tick();
    tlif.cmd_valid       = 1'b0;
  endtask

  task automatic wait_result(input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      check("result_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic clear_fault();
    tlif.fault_clr = 1'b1;
    tick();
    tlif.fault_clr = 1'b0;
    check("clr_fault", 32'(tlif.fault), 32'd0);
    check("clr_code", 32'(tlif.fault_code), 32'd0);
    check("clr_ready", 32'(tlif.cmd_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst                  = 1'b1;
    tlif.cmd_valid       = 1'b0;
    tlif.cmd_height      = '0;
    tlif.tray_height     = '0;
    tlif.tray_station    = 8'h01;
    tlif.station_changed = 1'b0;
    tlif.fault_clr       = 1'b0;
    #12;
    check("rst_ready", 32'(tlif.cmd_ready), 32'd1);
    check("rst_up", 32'(tlif.motor_up), 32'd0);
    check("rst_dn", 32'(tlif.motor_dn), 32'd0);
    check("rst_busy", 32'(tlif.busy), 32'd0);
    check("rst_done", 32'(tlif.done), 32'd0);
    check("rst_fault", 32'(tlif.fault), 32'd0);
    check("rst_code", 32'(tlif.fault_code), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Upward move with clean ramp
    send_cmd(32'd100, 32'd200, 32'd0);
    check("up_motor", 32'(tlif.motor_up), 32'd1);
    check("up_busy", 32'(tlif.busy), 32'd1);
    wait_result(400);
    check("up_height", tlif.tray_height, 32'd196);
    check("up_cycles", 32'(up_cycles), 32'd96);
    check("up_ready", 32'(tlif.cmd_ready), 32'd1);

    // Already in tolerance: settle only, exact done timing
    send_cmd(32'd500, 32'd503, 32'd0);
    repeat (7) tick();
    check("tol_done_early", 32'(tlif.done), 32'd0);
    check("tol_busy", 32'(tlif.busy), 32'd1);
    tick();
    check("tol_done", 32'(tlif.done), 32'd1);
    check("tol_ready_in_done", 32'(tlif.cmd_ready), 32'd0);
    tick();
    check("tol_done_end", 32'(tlif.done), 32'd0);
    check("tol_ready", 32'(tlif.cmd_ready), 32'd1);
    check("tol_no_motor", 32'(up_cycles), 32'd0);

    // Tolerance boundary: diff 4 settles, diff 5 needs one step
    send_cmd(32'd500, 32'd504, 32'd0);
    wait_result(40);
    check("tol4_no_motor", 32'(up_cycles), 32'd0);
    send_cmd(32'd500, 32'd505, 32'd0);
    wait_result(40);
    check("tol5_one_step", 32'(up_cycles), 32'd1);
    send_cmd(32'd2, 32'd0, 32'd0);
    check("low_no_wrap_dn", 32'(tlif.motor_dn), 32'd0);
    wait_result(40);

    // Stall in MOVE_UP
    stuck = 1'b1;
    send_cmd(32'd100, 32'd300, 32'd1);
    repeat (255) tick();
    check("stall_early", 32'(tlif.fault), 32'd0);
    check("stall_motor_on", 32'(tlif.motor_up), 32'd1);
    tick();
    check("stall_fault", 32'(tlif.fault), 32'd1);
    check("stall_code", 32'(tlif.fault_code), 32'd1);
    check("stall_motor_off", 32'(tlif.motor_up), 32'd0);
    check("stall_busy", 32'(tlif.busy), 32'd0);
    check("stall_ready", 32'(tlif.cmd_ready), 32'd0);
    wait_result(4);
    stuck = 1'b0;
    clear_fault();

    // Wrong direction while moving down
    send_cmd(32'd300, 32'd100, 32'd2);
    repeat (3) tick();
    check("dir_motor_dn", 32'(tlif.motor_dn), 32'd1);
    check("dir_fault_early", 32'(tlif.fault), 32'd0);
    tlif.tray_station = 8'h02;
    tick();
    check("dir_fault", 32'(tlif.fault), 32'd1);
    check("dir_code", 32'(tlif.fault_code), 32'd2);
    check("dir_motor_off", 32'(tlif.motor_dn), 32'd0);
    wait_result(4);
    clear_fault();

    // Overshoot corrected by one retry, ends at tolerance edge
    coast_left = 1;
    send_cmd(32'd100, 32'd200, 32'd0);
    wait_result(600);
    check("retry_ok_height", tlif.tray_height, 32'd204);

    // Overshoot every time: retries exhausted
    coast_left = 3;
    send_cmd(32'd100, 32'd200, 32'd3);
    wait_result(800);
    check("retry_code", 32'(tlif.fault_code), 32'd3);
    check("retry_up_off", 32'(tlif.motor_up), 32'd0);
    check("retry_dn_off", 32'(tlif.motor_dn), 32'd0);
    clear_fault();
    coast_left = 0;

    // Far target must not wrap into tolerance; async reset mid-move
    send_cmd(32'd0, 32'hFFFF_FFFF, 32'd0);
    check("far_motor_up", 32'(tlif.motor_up), 32'd1);
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_up", 32'(tlif.motor_up), 32'd0);
    check("arst_dn", 32'(tlif.motor_dn), 32'd0);
    check("arst_ready", 32'(tlif.cmd_ready), 32'd1);
    check("arst_busy", 32'(tlif.busy), 32'd0);
    check("arst_fault", 32'(tlif.fault), 32'd0);
    check("arst_code", 32'(tlif.fault_code), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_rst_ready", 32'(tlif.cmd_ready), 32'd1);
    check("post_rst_up", 32'(tlif.motor_up), 32'd0);

    // fault_clr outside FAULT is harmless
    tlif.fault_clr = 1'b1;
    tick();
    tlif.fault_clr = 1'b0;
    check("idle_clr_ready", 32'(tlif.cmd_ready), 32'd1);
    check("idle_clr_fault", 32'(tlif.fault), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
